uart_tx: RTL and testbench
==========================

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 The block SHALL have parameter CNT_BAUD_MAX, default 867, which is the last value of the baud counter; one bit lasts CNT_BAUD_MAX+1 sclk cycles.
REQ-002 The block SHALL have input sclk, 1 bit, the system clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have input rst_n, 1 bit: reset rst_n, asynchronous, active-low; clock sclk.
REQ-004 The block SHALL have input pi_data, 8 bits, the byte to transmit; it is sampled only when a byte is accepted.
REQ-005 The block SHALL have input pi_flag, 1 bit, a one-cycle request to transmit pi_data.
REQ-006 The block SHALL have output pi_ready, 1 bit, high when the holding register is empty and can accept a byte.
REQ-007 The block SHALL have output tx, 1 bit, the serial line; it idles high and is driven from a flop.
REQ-008 The block SHALL have output tx_busy, 1 bit, high whenever the FSM is not in IDLE.
REQ-009 The block SHALL have output tx_done, 1 bit, a one-cycle pulse at the end of each stop bit.

Function
REQ-010 The block SHALL accept a byte when pi_flag=1 and pi_ready=1 at a rising edge: pi_data loads into the holding register and pi_ready goes low at that edge.
REQ-011 The block SHALL ignore pi_flag while pi_ready=0: the byte is dropped and no state changes.
REQ-012 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP.
  - IDLE->START when the holding register is valid.
  - START->DATA after one bit time.
  - DATA->PARITY (macro defined) or DATA->STOP after 8 bit times.
  - PARITY->STOP after one bit time.
  - STOP->START if the holding register is valid, else STOP->IDLE, after one bit time.
REQ-013 On entering START, the block SHALL move the holding byte to the shift register, clear the holding valid bit (pi_ready=1 from that edge), and drive tx=0.
REQ-014 Latency SHALL be as follows: with pi_flag accepted at edge k while IDLE, tx SHALL be 0 after edge k+1.
REQ-015 DATA SHALL send LSB first; tx SHALL change only at bit boundaries, i.e. when the baud counter wraps from CNT_BAUD_MAX to 0.
REQ-016 The block SHALL use a 13-bit baud counter, held at 0 in IDLE, incrementing in every other state, and wrapping at CNT_BAUD_MAX.
REQ-017 The block SHALL use a 3-bit bit counter for DATA, which SHALL be 0 on entering DATA.
REQ-018 tx SHALL be 1 during STOP and IDLE.
REQ-019 tx_done SHALL pulse high for exactly one cycle on the edge at which STOP ends, including on back-to-back transfers.
REQ-020 Back-to-back transfers SHALL have no idle gap: the next start bit SHALL begin at the edge immediately after the previous stop bit ends.
REQ-021 If the FSM consumes the holding register at the same edge that pi_flag is high, pi_ready is still 0 at that edge, so the byte SHALL be dropped per REQ-011.

Reset
REQ-022 rst_n=0 SHALL force, asynchronously and mid-frame, the following values: tx=1, tx_busy=0, tx_done=0, pi_ready=1, FSM=IDLE, all counters 0, holding valid bit 0, shift/holding data 0.
REQ-023 After rst_n is released, the block SHALL remain in IDLE until a byte is accepted.

Configuration
REQ-024 When macro UART_TX_PARITY_EN is defined, the block SHALL add the PARITY state, sending the even-parity bit (XOR of the 8 data bits), for an 11-bit frame.
REQ-025 When UART_TX_PARITY_EN is undefined, the block SHALL have no PARITY state or logic, and the frame SHALL be 10 bits: 1 start, 8 data, 1 stop.

Verification
REQ-026 Test case: CNT_BAUD_MAX=3, no parity, send 0x55. Required response:
  - tx low 4 cycles, then bits 1,0,1,0,1,0,1,0 at 4 cycles each, then high 4 cycles.
  - tx_done pulse once.
  - tx_busy high for 40 cycles.
REQ-027 Test case: send 0xA5, then 0x3C while the first byte is in DATA. Required response:
  - Second start bit begins on the cycle after the first stop bit ends.
  - Two tx_done pulses, 40 cycles apart.
REQ-028 Test case: with the holding register full, pulse pi_flag with 0xFF. Required response: 0xFF is never transmitted and pi_ready stays 0.
REQ-029 Test case: assert rst_n=0 during data bit 3 of 0x0F. Required response:
  - tx=1 immediately.
  - tx_busy=0 and pi_ready=1.
  - After release, a new byte 0x81 is sent cleanly.
REQ-030 Test case: UART_TX_PARITY_EN defined, send 0x07. Required response: the parity bit is 1, the frame is 44 cycles at CNT_BAUD_MAX=3, and for 0x03 the parity bit is 0.

Source files
------------

// File: rtl/uart_tx.sv
// ---------------------------------------------------------------------------
// uart_tx : 8N1 UART transmitter with a one-byte holding register.
//
// Build option:
//   UART_TX_PARITY_EN  when defined, an even-parity bit is sent after the 8
//                      data bits (11-bit frame); otherwise the frame is
//                      1 start + 8 data + 1 stop (10 bits).
//
// Parameters:
//   CNT_BAUD_MAX  last value of the baud counter; one bit lasts
//                 CNT_BAUD_MAX+1 sclk cycles.
//
// Ports:
//   sclk      in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   pi_data   in   byte to transmit, sampled when accepted
//   pi_flag   in   one-cycle transmit request
//   pi_ready  out  holding register empty, a byte can be accepted
//   tx        out  serial line, idles high, registered
//   tx_busy   out  high whenever the FSM is not idle
//   tx_done   out  one-cycle pulse at the end of each stop bit
// ---------------------------------------------------------------------------
module uart_tx #(
  parameter int unsigned CNT_BAUD_MAX = 867
) (
  input  logic       sclk,
  input  logic       rst_n,
  input  logic [7:0] pi_data,
  input  logic       pi_flag,
  output logic       pi_ready,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam logic [12:0] LP_BAUD_MAX = 13'(CNT_BAUD_MAX);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t      r_state,      w_state;
  logic [12:0] r_baud_cnt,   w_baud_cnt;
  logic [2:0]  r_bit_cnt,    w_bit_cnt;
  logic [7:0]  r_hold_data,  w_hold_data;
  logic        r_hold_valid, w_hold_valid;
  logic [7:0]  r_shift,      w_shift;
  logic        r_tx,         w_tx;
  logic        r_done,       w_done;
  logic        w_bit_end;
  logic        w_load;
`ifdef UART_TX_PARITY_EN
  logic        r_parity,     w_parity;
`endif

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_baud_cnt   <= '0;
      r_bit_cnt    <= '0;
      r_hold_data  <= '0;
      r_hold_valid <= 1'b0;
      r_shift      <= '0;
      r_tx         <= 1'b1;
      r_done       <= 1'b0;
`ifdef UART_TX_PARITY_EN
      r_parity     <= 1'b0;
`endif
    end else begin
      r_state      <= w_state;
      r_baud_cnt   <= w_baud_cnt;
      r_bit_cnt    <= w_bit_cnt;
      r_hold_data  <= w_hold_data;
      r_hold_valid <= w_hold_valid;
      r_shift      <= w_shift;
      r_tx         <= w_tx;
      r_done       <= w_done;
`ifdef UART_TX_PARITY_EN
      r_parity     <= w_parity;
`endif
    end
  end

  always_comb begin
    w_state      = r_state;
    w_bit_cnt    = r_bit_cnt;
    w_hold_data  = r_hold_data;
    w_hold_valid = r_hold_valid;
    w_shift      = r_shift;
    w_tx         = r_tx;
    w_done       = 1'b0;
    w_load       = 1'b0;
`ifdef UART_TX_PARITY_EN
    w_parity     = r_parity;
`endif

    w_bit_end = (r_baud_cnt == LP_BAUD_MAX);

    if (r_state == IDLE) begin
      w_baud_cnt = '0;
    end else if (w_bit_end) begin
      w_baud_cnt = '0;
    end else begin
      w_baud_cnt = r_baud_cnt + 13'd1;
    end

    // Acceptance and consumption are mutually exclusive: accept needs the
    // holding register empty, consumption needs it full.
    if (pi_flag && !r_hold_valid) begin
      w_hold_valid = 1'b1;
      w_hold_data  = pi_data;
    end

    case (r_state)
      IDLE: begin
        if (r_hold_valid) begin
          w_load = 1'b1;
        end
      end
      START: begin
        if (w_bit_end) begin
          w_state   = DATA;
          w_bit_cnt = '0;
          w_tx      = r_shift[0];
        end
      end
      DATA: begin
        if (w_bit_end) begin
          if (r_bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            w_state = PARITY;
            w_tx    = r_parity;
`else
            w_state = STOP;
            w_tx    = 1'b1;
`endif
          end else begin
            // Shift first so the next bit to send is always at [0].
            w_bit_cnt = r_bit_cnt + 3'd1;
            w_shift   = r_shift >> 1;
            w_tx      = r_shift[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (w_bit_end) begin
          w_state = STOP;
          w_tx    = 1'b1;
        end
      end
`endif
      STOP: begin
        if (w_bit_end) begin
          w_done = 1'b1;
          if (r_hold_valid) begin
            w_load = 1'b1;
          end else begin
            w_state = IDLE;
          end
        end
      end
      default: begin
        w_state = IDLE;
        w_tx    = 1'b1;
      end
    endcase

    // Entering START: move holding byte into the shifter and free the slot.
    if (w_load) begin
      w_state      = START;
      w_shift      = r_hold_data;
      w_hold_valid = 1'b0;
      w_tx         = 1'b0;
`ifdef UART_TX_PARITY_EN
      w_parity     = ^r_hold_data;
`endif
    end
  end

  assign pi_ready = ~r_hold_valid;
  assign tx       = r_tx;
  assign tx_busy  = (r_state != IDLE);
  assign tx_done  = r_done;

endmodule

// File: tb/tb_uart_tx.sv
module tb_uart_tx;

  localparam int unsigned BAUD_MAX = 3;
  localparam int unsigned B        = BAUD_MAX + 1;
`ifdef UART_TX_PARITY_EN
  localparam int unsigned F        = 11;
`else
  localparam int unsigned F        = 10;
`endif

  logic       sclk;
  logic       rst_n;
  logic [7:0] pi_data;
  logic       pi_flag;
  logic       pi_ready;
  logic       tx;
  logic       tx_busy;
  logic       tx_done;

  uart_tx #(.CNT_BAUD_MAX(BAUD_MAX)) dut (
    .sclk    (sclk),
    .rst_n   (rst_n),
    .pi_data (pi_data),
    .pi_flag (pi_flag),
    .pi_ready(pi_ready),
    .tx      (tx),
    .tx_busy (tx_busy),
    .tx_done (tx_done)
  );

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a frame is a list of F bits, each B cycles long,
  // starting the edge after the holding slot became full (or right at the
  // end edge of the previous frame).
  logic        m_active;
  int unsigned m_pos;
  logic [7:0]  m_cur;
  logic        m_hold;
  logic [7:0]  m_hold_byte;
  logic        m_done;

  function automatic logic frame_bit(input logic [7:0] b, input int unsigned i);
    if (i == 0) return 1'b0;
    if (i <= 8) return b[i-1];
`ifdef UART_TX_PARITY_EN
    if (i == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_active = 1'b0; m_pos = 0; m_cur = '0;
    m_hold = 1'b0; m_hold_byte = '0; m_done = 1'b0;
  endtask

  task automatic model_edge(input logic f, input logic [7:0] d);
    logic pre_hold;
    if (!rst_n) begin
      model_reset();
      return;
    end
    pre_hold = m_hold;
    m_done   = 1'b0;
    if (m_active) begin
      m_pos++;
      if (m_pos == F * B) begin
        m_active = 1'b0;
        m_done   = 1'b1;
      end
    end
    if (!m_active && pre_hold) begin
      m_active = 1'b1;
      m_pos    = 0;
      m_cur    = m_hold_byte;
      m_hold   = 1'b0;
    end
    if (f && !pre_hold) begin
      m_hold      = 1'b1;
      m_hold_byte = d;
    end
  endtask

  task automatic check_all();
    chk("tx",    32'(tx),       32'(m_active ? frame_bit(m_cur, m_pos / B) : 1'b1));
    chk("busy",  32'(tx_busy),  32'(m_active));
    chk("done",  32'(tx_done),  32'(m_done));
    chk("ready", 32'(pi_ready), 32'(!m_hold));
  endtask

  // Called at a falling edge; drives inputs, runs one rising edge, checks.
  task automatic step(input logic f, input logic [7:0] d);
    pi_flag = f;
    pi_data = d;
    @(posedge sclk);
    model_edge(f, d);
    @(negedge sclk);
    check_all();
  endtask

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;   // {stop, d7..d0, start}; bit 0 goes out first
    logic       par;
  } vec_t;

  vec_t vecs[9];

  task automatic run_vec(input vec_t v);
    int unsigned busy_cnt;
    int unsigned done_cnt;
    logic        exp_bit;
    busy_cnt = 0;
    done_cnt = 0;
    step(1'b1, v.data);
    for (int unsigned j = 0; j < F * B; j++) begin
      step(1'b0, 8'h00);
      if (j == 0) chk("latency_start", 32'(tx), 32'(0));
      if (j % B == B / 2) begin
        if (j / B < 9)       exp_bit = v.frame[j / B];
`ifdef UART_TX_PARITY_EN
        else if (j / B == 9) exp_bit = v.par;
`endif
        else                 exp_bit = 1'b1;
        chk($sformatf("bit%0d_of_%02h", j / B, v.data), 32'(tx), 32'(exp_bit));
      end
      busy_cnt += 32'(tx_busy);
      done_cnt += 32'(tx_done);
    end
    step(1'b0, 8'h00);
    chk("done_at_end", 32'(tx_done), 32'(1));
    busy_cnt += 32'(tx_busy);
    done_cnt += 32'(tx_done);
    for (int unsigned j = 0; j < 3; j++) begin
      step(1'b0, 8'h00);
      busy_cnt += 32'(tx_busy);
      done_cnt += 32'(tx_done);
    end
    chk("busy_cycles", busy_cnt, F * B);
    chk("done_pulses", done_cnt, 1);
  endtask

  initial begin
    int unsigned dones;
    int unsigned t_first;
    int unsigned t_second;
    int unsigned cyc;
    logic        tx_at_done;

    vecs[0] = '{8'h55, 10'b1010101010, 1'b0};
    vecs[1] = '{8'h0F, 10'b1000011110, 1'b0};
    vecs[2] = '{8'h81, 10'b1100000010, 1'b0};
    vecs[3] = '{8'hA5, 10'b1101001010, 1'b0};
    vecs[4] = '{8'h07, 10'b1000001110, 1'b1};
    vecs[5] = '{8'h03, 10'b1000000110, 1'b0};
    vecs[6] = '{8'h00, 10'b1000000000, 1'b0};
    vecs[7] = '{8'hFF, 10'b1111111110, 1'b0};
    vecs[8] = '{8'h01, 10'b1000000010, 1'b1};

    pi_flag = 1'b0;
    pi_data = 8'h00;
    rst_n   = 1'b1;
    model_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_tx",    32'(tx),       32'(1));
    chk("rst_busy",  32'(tx_busy),  32'(0));
    chk("rst_done",  32'(tx_done),  32'(0));
    chk("rst_ready", 32'(pi_ready), 32'(1));
    @(negedge sclk);
    rst_n = 1'b1;
    for (int unsigned i = 0; i < 5; i++) step(1'b0, 8'h00);

    // Directed single frames.
    foreach (vecs[i]) run_vec(vecs[i]);

    // Back-to-back: second byte loaded during DATA, a full-slot drop, and a
    // request landing on the very edge the slot is consumed.
    step(1'b1, 8'hA5);
    step(1'b0, 8'h00);                       // start edge, pos 0
    for (int unsigned p = 1; p < F * B; p++) begin
      if (p == 10)      step(1'b1, 8'h3C);   // accepted, slot full
      else if (p == 12) begin
        step(1'b1, 8'hFF);                   // slot full: dropped
        chk("drop_ready", 32'(pi_ready), 32'(0));
      end else          step(1'b0, 8'h00);
    end
    step(1'b1, 8'h99);                       // end edge: slot consumed, 0x99 dropped
    chk("b2b_done",       32'(tx_done),  32'(1));
    chk("b2b_no_gap_tx",  32'(tx),       32'(0));
    chk("race_ready",     32'(pi_ready), 32'(1));
    chk("b2b_busy",       32'(tx_busy),  32'(1));
    for (int unsigned p = 0; p < F * B + 4; p++) step(1'b0, 8'h00);

    // Two-pulse spacing measured independently.
    dones = 0; t_first = 0; t_second = 0; tx_at_done = 1'b1;
    step(1'b1, 8'hA5);
    for (cyc = 0; cyc < 4 * F * B && dones < 2; cyc++) begin
      step((cyc == 12) ? 1'b1 : 1'b0, 8'h3C);
      if (tx_done) begin
        if (dones == 0) begin
          t_first    = cyc;
          tx_at_done = tx;
        end else begin
          t_second = cyc;
        end
        dones++;
      end
    end
    chk("pair_pulses",  dones, 2);
    chk("pair_spacing", t_second - t_first, F * B);
    chk("pair_restart", 32'(tx_at_done), 32'(0));
    for (int unsigned p = 0; p < 4; p++) step(1'b0, 8'h00);

    // Asynchronous reset in data bit 3 of 0x0F, then a clean 0x81.
    step(1'b1, 8'h0F);
    step(1'b0, 8'h00);
    for (int unsigned p = 1; p <= 17; p++) step(1'b0, 8'h00);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("midrst_tx",    32'(tx),       32'(1));
    chk("midrst_busy",  32'(tx_busy),  32'(0));
    chk("midrst_ready", 32'(pi_ready), 32'(1));
    chk("midrst_done",  32'(tx_done),  32'(0));
    @(negedge sclk);
    step(1'b1, 8'h5A);                       // ignored while in reset
    rst_n = 1'b1;
    for (int unsigned p = 0; p < 6; p++) step(1'b0, 8'h00);
    run_vec(vecs[2]);

    // Random traffic against the model.
    for (int unsigned p = 0; p < 3000; p++) begin
      step(($urandom_range(0, 11) == 0) ? 1'b1 : 1'b0, 8'($urandom));
    end
    for (int unsigned p = 0; p < 2 * F * B + 4; p++) step(1'b0, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
